// File: rtl/vm_pkg.sv
// Shared types and constants for the parametrised vending-machine controller.
package vm_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} vm_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN0     = 2'b01;
    localparam logic [1:0] COIN1     = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    function automatic int calc_cw(input int max_credit);
        return $clog2(max_credit + 1);
    endfunction

endpackage

// File: rtl/vm_change_pacer.sv
// Paces change return: one D_C pulse per CHG_UNIT, high one cycle then a one-cycle gap.
module vm_change_pacer #(
    parameter int CW       = 4,
    parameter int CHG_UNIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_amt,
    output logic          d_c,
    output logic          done
);

    localparam logic [CW-1:0] UNIT = CW'(CHG_UNIT);

    logic [CW-1:0] remain;
    logic          ph;
    logic          active;

    // done marks the final gap cycle, so the owner can leave CHANGE on the same edge
    assign done = active & ph & (remain == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= '0;
            ph     <= 1'b0;
            active <= 1'b0;
            d_c    <= 1'b0;
        end else if (load) begin
            remain <= load_amt;
            ph     <= 1'b0;
            active <= 1'b1;
            d_c    <= 1'b1;
        end else if (active) begin
            if (!ph) begin
                remain <= (remain >= UNIT) ? remain - UNIT : '0;
                ph     <= 1'b1;
                d_c    <= 1'b0;
            end else if (remain == '0) begin
                active <= 1'b0;
                ph     <= 1'b0;
            end else begin
                ph  <= 1'b0;
                d_c <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm_ctrl_param.sv
// Vending-machine controller: credit accumulation, vend at PRICE, paced change/refund.
module vm_ctrl_param
    import vm_pkg::*;
#(
    parameter int COIN0_VAL  = 1,
    parameter int COIN1_VAL  = 2,
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15,
    parameter int CHG_UNIT   = 1,
    parameter int CW         = calc_cw(MAX_CREDIT)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [1:0]    D_in,
    input  logic          Cancel,
    output logic          D_out,
    output logic          D_C,
    output logic          Coin_rej,
    output logic [CW-1:0] Credit,
    output logic          Busy
);

    localparam logic [CW:0]   MAX_W   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW:0]   PRICE_W = (CW+1)'(PRICE);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW-1:0] UNIT    = CW'(CHG_UNIT);

    vm_state_t     state;
    logic [CW:0]   coin_val;
    logic [CW:0]   sum;
    logic          coin_in, coin_ok, take_cancel, load, pace_done;
    logic [CW-1:0] vend_resid, load_amt;

    always_comb begin
        coin_val = '0;
        case (D_in)
            COIN0:   coin_val = (CW+1)'(COIN0_VAL);
            COIN1:   coin_val = (CW+1)'(COIN1_VAL);
            default: coin_val = '0;
        endcase
    end

    // sum is one bit wider than Credit so saturation is checked before anything can wrap
    assign sum         = {1'b0, Credit} + coin_val;
    assign coin_in     = (D_in != COIN_NONE);
    assign coin_ok     = (D_in == COIN0 || D_in == COIN1) && (sum <= MAX_W);
    assign take_cancel = (state == IDLE || state == ACCUM) && Cancel;
    assign vend_resid  = (Credit >= PRICE_C) ? Credit - PRICE_C : '0;
    assign load        = (take_cancel && Credit != '0) || (state == VEND && vend_resid != '0);
    assign load_amt    = (state == VEND) ? vend_resid : Credit;

    vm_change_pacer #(.CW(CW), .CHG_UNIT(CHG_UNIT)) u_pacer (
        .clk      (Clk),
        .rst      (Reset),
        .load     (load),
        .load_amt (load_amt),
        .d_c      (D_C),
        .done     (pace_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Credit   <= '0;
            D_out    <= 1'b0;
            Coin_rej <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            D_out    <= 1'b0;
            Coin_rej <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (Cancel) begin
                        Coin_rej <= coin_in;
                        if (Credit != '0) begin
                            state <= CHANGE;
                            Busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (coin_in) begin
                        if (coin_ok) begin
                            Credit <= sum[CW-1:0];
                            if (sum >= PRICE_W) begin
                                state <= VEND;
                                D_out <= 1'b1;
                                Busy  <= 1'b1;
                            end else begin
                                state <= ACCUM;
                            end
                        end else begin
                            Coin_rej <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    Coin_rej <= coin_in;
                    Credit   <= vend_resid;
                    if (vend_resid != '0) begin
                        state <= CHANGE;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                CHANGE: begin
                    Coin_rej <= coin_in;
                    // D_C high means this is the pulse cycle; the unit leaves Credit at its end
                    if (D_C)
                        Credit <= (Credit >= UNIT) ? Credit - UNIT : '0;
                    if (pace_done) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_ctrl_param.sv
// Bench for vm_ctrl_param: directed scenarios plus random traffic against a plan-queue model.
module tb_vm_ctrl_param;

    localparam int PRICE = 5;
    localparam int MAXC  = 15;
    localparam int CHG   = 1;
    localparam int V0    = 1;
    localparam int V1    = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] D_in = 2'b00;
    logic       Cancel = 1'b0;
    logic       D_out, D_C, Coin_rej, Busy;
    logic [3:0] Credit;

    logic [1:0] d_in2 = 2'b00;
    logic       d_out2, d_c2, rej2, busy2;
    logic [3:0] credit2;

    int ntests = 0;
    int nfail  = 0;

    always #5 Clk = ~Clk;

    vm_ctrl_param dut (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .Cancel(Cancel),
        .D_out(D_out), .D_C(D_C), .Coin_rej(Coin_rej), .Credit(Credit), .Busy(Busy)
    );

    vm_ctrl_param #(.PRICE(15), .MAX_CREDIT(15)) u_p15 (
        .Clk(Clk), .Reset(Reset), .D_in(d_in2), .Cancel(1'b0),
        .D_out(d_out2), .D_C(d_c2), .Coin_rej(rej2), .Credit(credit2), .Busy(busy2)
    );

    // Model: each busy period is precomputed as a list of expected per-cycle outputs.
    typedef struct { logic d_out; logic d_c; int cr; } ent_t;
    ent_t q[$];
    int   m_cr = 0;
    logic m_busy = 1'b0;
    logic e_out, e_dc, e_rej, e_busy;
    int   e_cr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic plan_refund(input int amt);
        int r = amt;
        while (r > 0) begin
            q.push_back('{1'b0, 1'b1, r});
            q.push_back('{1'b0, 1'b0, r - CHG});
            r -= CHG;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cr = 0;
        m_busy = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] din, input logic cancel);
        ent_t e;
        int   val;
        e_rej = 1'b0; e_out = 1'b0; e_dc = 1'b0;
        if (!m_busy) begin
            if (cancel) begin
                e_rej = (din != 2'b00);
                if (m_cr > 0) begin
                    plan_refund(m_cr);
                    m_cr = 0;
                end
            end else if (din == 2'b01 || din == 2'b10) begin
                val = (din == 2'b01) ? V0 : V1;
                if (m_cr + val <= MAXC) begin
                    m_cr += val;
                    if (m_cr >= PRICE) begin
                        q.push_back('{1'b1, 1'b0, m_cr});
                        plan_refund(m_cr - PRICE);
                        m_cr = 0;
                    end
                end else begin
                    e_rej = 1'b1;
                end
            end else if (din == 2'b11) begin
                e_rej = 1'b1;
            end
        end else begin
            e_rej = (din != 2'b00);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            e_out = e.d_out; e_dc = e.d_c; e_cr = e.cr;
            m_busy = 1'b1;
        end else begin
            m_busy = 1'b0;
            e_cr = m_cr;
        end
        e_busy = m_busy;
    endtask

    task automatic cyc(input logic [1:0] din, input logic cancel, input logic [1:0] din2);
        @(negedge Clk);
        D_in = din; Cancel = cancel; d_in2 = din2;
        model_step(din, cancel);
        @(posedge Clk);
        #1;
        chk("d_out", D_out, e_out);
        chk("d_c", D_C, e_dc);
        chk("coin_rej", Coin_rej, e_rej);
        chk("busy", Busy, e_busy);
        chk("credit", Credit, e_cr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 2'b00);
    endtask

    initial begin
        int pulses, vends;
        logic [1:0] din;
        logic cancel;
        int r;

        #12;
        chk("rst_d_out", D_out, 0);
        chk("rst_d_c", D_C, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_credit", Credit, 0);
        chk("rst_rej", Coin_rej, 0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();

        // exact pay
        cyc(2'b10, 1'b0, 2'b00);
        chk("exact_cr1", Credit, 2);
        cyc(2'b10, 1'b0, 2'b00);
        chk("exact_cr2", Credit, 4);
        cyc(2'b01, 1'b0, 2'b00);
        chk("exact_dout", D_out, 1);
        chk("exact_cr3", Credit, 5);
        cyc(2'b00, 1'b0, 2'b00);
        chk("exact_no_dc", D_C, 0);
        chk("exact_cr0", Credit, 0);
        idle(2);

        // overpay: one change pulse
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b10, 1'b0, 2'b00);
        chk("over_cr6", Credit, 6);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(2'b00, 1'b0, 2'b00);
            pulses += int'(D_C);
        end
        chk("over_pulses", pulses, 1);

        // cancel refund of 3 units
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b01, 1'b0, 2'b00);
        cyc(2'b00, 1'b1, 2'b00);
        pulses = (D_C === 1'b1) ? 1 : 0;
        vends = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(2'b00, 1'b0, 2'b00);
            pulses += int'(D_C);
            vends  += int'(D_out);
        end
        chk("cancel_pulses", pulses, 3);
        chk("cancel_no_vend", vends, 0);

        // invalid coin code in IDLE
        cyc(2'b11, 1'b0, 2'b00);
        chk("bad_rej", Coin_rej, 1);
        chk("bad_cr", Credit, 0);
        idle(1);

        // coins during VEND/CHANGE are rejected and do not alter change
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b01, 1'b0, 2'b00);
        cyc(2'b10, 1'b0, 2'b00);
        chk("busy_rej", Coin_rej, 1);
        cyc(2'b01, 1'b1, 2'b00);
        idle(3);

        // cancel wins over a coin in the same cycle
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b01, 1'b1, 2'b00);
        chk("cc_rej", Coin_rej, 1);
        pulses = int'(D_C);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b00, 1'b0, 2'b00);
            pulses += int'(D_C);
        end
        chk("cc_pulses", pulses, 2);
        chk("cc_cr", Credit, 0);
        idle(1);

        // asynchronous reset mid-change, after the first pulse
        cyc(2'b10, 1'b0, 2'b00);
        cyc(2'b01, 1'b0, 2'b00);
        cyc(2'b00, 1'b1, 2'b00);
        cyc(2'b00, 1'b0, 2'b00);
        cyc(2'b00, 1'b0, 2'b00);
        chk("pre_rst_dc", D_C, 1);
        #2 Reset = 1'b1;
        #1;
        chk("arst_dc", D_C, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_cr", Credit, 0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        cyc(2'b01, 1'b0, 2'b00);
        chk("post_rst_cr", Credit, 1);
        cyc(2'b00, 1'b1, 2'b00);
        idle(3);

        // saturation on the PRICE=15 instance
        for (int i = 1; i <= 7; i++) begin
            cyc(2'b00, 1'b0, 2'b10);
            chk("p15_cr", credit2, 2 * i);
        end
        cyc(2'b00, 1'b0, 2'b10);
        chk("p15_sat_rej", rej2, 1);
        chk("p15_sat_cr", credit2, 14);
        cyc(2'b00, 1'b0, 2'b01);
        chk("p15_vend", d_out2, 1);
        chk("p15_vend_cr", credit2, 15);
        cyc(2'b00, 1'b0, 2'b00);
        chk("p15_end_cr", credit2, 0);
        chk("p15_end_busy", busy2, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            din = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            cancel = ($urandom_range(0, 11) == 0);
            cyc(din, cancel, 2'b00);
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
